// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2^2 SDF FFT stages.
package fft_pkg;
    localparam int WIDTH = 17;
    localparam int DELAY = 2;

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // ST_PRIME: phase-A reads still return stale delay contents and are not emitted.
    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;
endpackage

// File: rtl/sdf_stage_d2_if.sv
// Sample stream into and out of one SDF stage.
// Handshake: valid-only streams with no backpressure; a sample moves on every
// clock edge where its valid is 1, and start is meaningful only alongside valid.
interface sdf_stage_d2_if #(
    parameter int WIDTH = fft_pkg::WIDTH
);
    logic                    in_valid;
    logic                    in_start;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    out_valid;
    logic                    out_start;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;

    modport master (
        output in_valid, in_start, in_re, in_im,
        input  out_valid, out_start, out_re, out_im
    );

    modport slave (
        input  in_valid, in_start, in_re, in_im,
        output out_valid, out_start, out_re, out_im
    );
endinterface

// File: rtl/bf2_core.sv
// Scaled radix-2 butterfly on one real component: s=(a+b)>>>1, t=(a-b)>>>1.
module bf2_core #(
    parameter int WIDTH = fft_pkg::WIDTH
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] s,
    output logic signed [WIDTH-1:0] t
);
    logic signed [WIDTH:0] sum;
    logic signed [WIDTH:0] dif;

    // One guard bit keeps the full result; the halved value always fits WIDTH.
    assign sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign dif = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign s   = WIDTH'(sum >>> 1);
    assign t   = WIDTH'(dif >>> 1);
endmodule

// File: rtl/sdf_stage_d2.sv
// Single-delay-feedback FFT stage with a 2-sample delay line and -j twiddle on d[1].
module sdf_stage_d2
    import fft_pkg::*;
#(
    parameter int WIDTH = fft_pkg::WIDTH,
    parameter int DELAY = fft_pkg::DELAY
) (
    input  logic           clk,
    input  logic           rst,
    sdf_stage_d2_if.slave  bus,
    output state_t         dbg_state
);
    logic [1:0]              cnt;
    logic signed [WIDTH-1:0] d_re [DELAY];
    logic signed [WIDTH-1:0] d_im [DELAY];
    state_t                  state;
    state_t                  state_nxt;

    logic                    accept;
    logic [1:0]              phase;
    logic                    phase_a;
    logic                    idx;
    logic                    restart;
    logic                    prime_now;
    logic                    emit;
    logic signed [WIDTH-1:0] s_re, s_im, t_re, t_im;
    logic signed [WIDTH-1:0] rot_re, rot_im;
    logic signed [WIDTH-1:0] sel_re, sel_im;

    assign accept  = bus.in_valid;
    assign phase   = bus.in_start ? 2'd0 : cnt;
    assign phase_a = ~phase[1];
    assign idx     = phase[0];
    // A start arriving mid-block means the stored differences belong to a broken block.
    assign restart = bus.in_start && (cnt != 2'd0);

    bf2_core #(.WIDTH(WIDTH)) u_bf_re (.a(d_re[idx]), .b(bus.in_re), .s(s_re), .t(t_re));
    bf2_core #(.WIDTH(WIDTH)) u_bf_im (.a(d_im[idx]), .b(bus.in_im), .s(s_im), .t(t_im));

    // Multiply by -j: (a + jb)(-j) = b - ja, with the negation clamped.
    assign rot_re = d_im[1];
    assign rot_im = (d_re[1] == SAT_MIN) ? SAT_MAX : -d_re[1];

    always_comb begin
        sel_re = s_re;
        sel_im = s_im;
        if (phase_a) begin
            sel_re = idx ? rot_re : d_re[0];
            sel_im = idx ? rot_im : d_im[0];
        end
    end

    always_comb begin
        state_nxt = state;
        prime_now = 1'b1;
        unique case (state)
            ST_PRIME: prime_now = 1'b1;
            ST_RUN:   prime_now = restart;
        endcase
        if (accept) begin
            state_nxt = (prime_now && !(phase_a && idx)) ? ST_PRIME : ST_RUN;
        end
        emit = accept && !(prime_now && phase_a);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 2'd0;
            bus.out_valid <= 1'b0;
            bus.out_start <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            for (int i = 0; i < DELAY; i++) begin
                d_re[i] <= '0;
                d_im[i] <= '0;
            end
        end else begin
            bus.out_valid <= emit;
            bus.out_start <= emit && (phase == 2'd2);
            if (accept) begin
                cnt <= phase + 2'd1;
                if (phase_a) begin
                    d_re[idx] <= bus.in_re;
                    d_im[idx] <= bus.in_im;
                end else begin
                    d_re[idx] <= t_re;
                    d_im[idx] <= t_im;
                end
            end
            if (emit) begin
                bus.out_re <= sel_re;
                bus.out_im <= sel_im;
            end
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_sdf_stage_d2.sv
// Directed and random stimulus for sdf_stage_d2 checked against an integer reference model.
module tb_sdf_stage_d2;
    localparam int W    = 17;
    localparam int MAXV = (1 << (W - 1)) - 1;

    logic clk;
    logic rst;
    fft_pkg::state_t dbg_state;

    sdf_stage_d2_if #(.WIDTH(W)) bus ();

    sdf_stage_d2 #(.WIDTH(W), .DELAY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state, held as plain integers.
    int m_cnt;
    int m_dre [2];
    int m_dim [2];
    bit m_prime;
    bit e_valid;
    bit e_start;
    int e_re;
    int e_im;

    function automatic int half(input int v);
        return v >>> 1;
    endfunction

    function automatic void model_update(input bit r, input bit v, input bit s, input int re, input int im);
        int k;
        if (r) begin
            m_cnt = 0; m_dre = '{0, 0}; m_dim = '{0, 0}; m_prime = 1;
            e_valid = 0; e_start = 0; e_re = 0; e_im = 0;
            return;
        end
        e_valid = 0;
        e_start = 0;
        if (!v) return;
        if (s) begin
            if (m_cnt != 0) m_prime = 1;
            m_cnt = 0;
        end
        k = m_cnt % 2;
        if (m_cnt < 2) begin
            if (!m_prime) begin
                e_valid = 1;
                if (k == 0) begin
                    e_re = m_dre[0];
                    e_im = m_dim[0];
                end else begin
                    e_re = m_dim[1];
                    e_im = (-m_dre[1] > MAXV) ? MAXV : -m_dre[1];
                end
            end
            m_dre[k] = re;
            m_dim[k] = im;
            if (m_cnt == 1) m_prime = 0;
        end else begin
            e_valid = 1;
            e_start = (m_cnt == 2);
            e_re = half(m_dre[k] + re);
            e_im = half(m_dim[k] + im);
            m_dre[k] = half(m_dre[k] - re);
            m_dim[k] = half(m_dim[k] - im);
        end
        m_cnt = (m_cnt + 1) % 4;
    endfunction

    task automatic chk(input string tag, input logic signed [W-1:0] obs, input logic signed [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic signed [W-1:0] er;
        logic signed [W-1:0] ei;
        er = W'(e_re);
        ei = W'(e_im);
        chk({tag, ".valid"}, W'(bus.out_valid), W'(e_valid));
        chk({tag, ".start"}, W'(bus.out_start), W'(e_start));
        chk({tag, ".re"}, bus.out_re, er);
        chk({tag, ".im"}, bus.out_im, ei);
    endtask

    task automatic step(input string tag, input bit r, input bit v, input bit s, input int re, input int im);
        rst          = r;
        bus.in_valid = v;
        bus.in_start = s;
        bus.in_re    = W'(re);
        bus.in_im    = W'(im);
        @(posedge clk);
        model_update(r, v, s, re, im);
        #1;
        check_outputs(tag);
    endtask

    task automatic sample(input string tag, input bit s, input int re, input int im);
        step(tag, 1'b0, 1'b1, s, re, im);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int blk_a [4];
        int blk_b [4];
        blk_a = '{4, 8, 2, 6};
        blk_b = '{1, 1, 1, 1};

        // Reset state
        step("reset0", 1'b1, 1'b0, 1'b0, 0, 0);
        step("reset1", 1'b1, 1'b1, 1'b1, 123, -45);

        // Contiguous block 4,8,2,6 then 1,1,1,1
        for (int i = 0; i < 4; i++) sample("blk_a", i == 0, blk_a[i], 0);
        for (int i = 0; i < 4; i++) begin
            sample("blk_b", i == 0, blk_b[i], 0);
            if (i == 1) begin
                chk("blk_b_rot.re", bus.out_re, 0);
                chk("blk_b_rot.im", bus.out_im, -1);
            end
        end

        // Saturating rotation of d[1] = -65536
        sample("sat_b0", 1'b1, 0, 0);
        sample("sat_b1", 1'b0, -65536, 0);
        sample("sat_b2", 1'b0, 0, 0);
        sample("sat_b3", 1'b0, 65535, 0);
        sample("sat_n0", 1'b1, 0, 0);
        sample("sat_n1", 1'b0, 0, 0);
        chk("sat_lit.re", bus.out_re, 0);
        chk("sat_lit.im", bus.out_im, 65535);
        sample("sat_n2", 1'b0, 0, 0);
        sample("sat_n3", 1'b0, 0, 0);

        // Same two blocks with 3 idle cycles after every sample
        step("gap_rst", 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            sample("gap_a", i == 0, blk_a[i], 0);
            if (i == 2) chk("gap_a_sum0", bus.out_re, 3);
            if (i == 3) chk("gap_a_sum1", bus.out_re, 7);
            idle("gap_idle", 3);
        end
        for (int i = 0; i < 4; i++) begin
            sample("gap_b", i == 0, blk_b[i], 0);
            idle("gap_idle", 3);
        end

        // Start ignored while in_valid is low
        sample("ign0", 1'b1, 10, 20);
        step("ign_start", 1'b0, 1'b0, 1'b1, 0, 0);
        sample("ign1", 1'b0, 30, 40);
        sample("ign2", 1'b0, 50, 60);
        sample("ign3", 1'b0, 70, 80);

        // Start at cnt=2 re-primes and resyncs
        sample("rs0", 1'b1, 100, 5);
        sample("rs1", 1'b0, 200, 6);
        sample("rs2", 1'b1, 300, 7);
        sample("rs3", 1'b0, 400, 8);
        sample("rs4", 1'b0, 500, 9);
        sample("rs5", 1'b0, 600, 10);
        for (int i = 0; i < 4; i++) sample("rs_next", i == 0, 11 * i - 7, 3 - i);

        // Reset after cnt=1, colliding with a valid sample
        sample("mr0", 1'b1, 9, 9);
        sample("mr1", 1'b0, 8, 8);
        step("mr_rst", 1'b1, 1'b1, 1'b0, 77, 77);
        chk("mr_zero.re", bus.out_re, 0);
        for (int i = 0; i < 4; i++) sample("mr_blk_a", i == 0, blk_a[i], 0);
        for (int i = 0; i < 4; i++) sample("mr_blk_b", i == 0, blk_b[i], 0);

        // Random traffic including extreme values, gaps, stray starts and resets
        for (int n = 0; n < 400; n++) begin
            bit r, v, s;
            int re, im;
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 9) < 7);
            s  = ($urandom_range(0, 9) == 0);
            re = int'($urandom_range(0, 131071)) - 65536;
            im = int'($urandom_range(0, 131071)) - 65536;
            if ($urandom_range(0, 9) == 0) re = -65536;
            step("rand", r, v, s, re, im);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
